// File: rtl/axi_noc_pkg.sv
// Shared AXI constants, FSM state types and burst helpers for the slave 1 memory.
package axi_noc_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;

  localparam logic [31:0] S1_BASE_ADDR = 32'h0000_2000;
  localparam logic [31:0] S1_END_ADDR  = 32'h0000_2FFF;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_t;

  // Only full-word INCR/FIXED bursts are serviced; anything else is a slave error.
  function automatic logic burst_ok(input logic [1:0] burst, input logic [2:0] size);
    return (burst != WRAP) && (size == 3'd2);
  endfunction

  // INCR steps one word per beat, every other burst type holds the address.
  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst);
    return (burst == INCR) ? addr + 32'd4 : addr;
  endfunction

endpackage

// File: rtl/axi_s1_mem_array.sv
// Byte-enabled 32-bit storage: one synchronous write port, one combinational read port.
// Contents are never reset.
module axi_s1_mem_array #(
  parameter int unsigned WORDS = 1024,
  parameter int unsigned IDXW  = 10
) (
  input  logic            i_clk,
  input  logic            i_we,
  input  logic [IDXW-1:0] i_widx,
  input  logic [3:0]      i_wbe,
  input  logic [31:0]     i_wdata,
  input  logic [IDXW-1:0] i_ridx,
  output logic [31:0]     o_rdata
);

  logic [31:0] r_mem [WORDS];

  // Byte-lane write; a read of the same word in this cycle still sees the old value.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (i_wbe[b]) r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/axi_slave1_mem.sv
// AXI slave 1 memory: independent write and read FSMs over a byte-enabled RAM.
// Optional feature macro: AXI_S1_WAIT_STATE_EN (RESP_DELAY wait states on B and every R beat).
module axi_slave1_mem
  import axi_noc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = S1_BASE_ADDR,
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned RESP_DELAY = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [5:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [5:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [5:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  output logic [5:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready
);

  localparam int unsigned IDXW     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [31:0] END_ADDR = BASE_ADDR + 32'(4 * MEM_WORDS) - 32'd1;

  function automatic logic in_win(input logic [31:0] a);
    return (a >= BASE_ADDR) && (a <= END_ADDR);
  endfunction

  function automatic logic [IDXW-1:0] word_idx(input logic [31:0] a);
    return IDXW'((a - BASE_ADDR) >> 2);
  endfunction

  // Write channel state
  wr_state_t   r_wstate;
  logic [5:0]  r_awid;
  logic [31:0] r_waddr;
  logic [1:0]  r_wburst;
  logic [2:0]  r_wsize;
  logic        r_slverr, r_decerr;
  logic        r_awready, r_wready, r_bvalid;
  logic [5:0]  r_bid;
  logic [1:0]  r_bresp;

  // Read channel state
  rd_state_t   r_rstate;
  logic [31:0] r_raddr;
  logic [1:0]  r_rburst;
  logic [2:0]  r_rsize;
  logic [7:0]  r_rlen, r_rbeat;
  logic        r_arready, r_rvalid, r_rlast;
  logic [5:0]  r_rid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;

`ifdef AXI_S1_WAIT_STATE_EN
  logic [7:0]  r_wcnt, r_rcnt;
`endif

  logic        w_wr_hs, w_wr_inwin, w_wr_bok, w_mem_we;
  logic [31:0] w_rd_addr, w_mem_rdata, w_beat_data;
  logic [1:0]  w_rd_burst, w_beat_resp;
  logic [2:0]  w_rd_size;
  logic        w_rd_inwin, w_rd_bok;

  assign w_wr_hs    = r_wready & wvalid;
  assign w_wr_inwin = in_win(r_waddr);
  assign w_wr_bok   = burst_ok(r_wburst, r_wsize);
  assign w_mem_we   = w_wr_hs & w_wr_inwin & w_wr_bok;

  // The beat being fetched comes straight from the AR inputs while idle so the first
  // beat can be registered on the handshake edge itself.
  assign w_rd_addr   = (r_rstate == R_IDLE) ? araddr  : r_raddr;
  assign w_rd_burst  = (r_rstate == R_IDLE) ? arburst : r_rburst;
  assign w_rd_size   = (r_rstate == R_IDLE) ? arsize  : r_rsize;
  assign w_rd_inwin  = in_win(w_rd_addr);
  assign w_rd_bok    = burst_ok(w_rd_burst, w_rd_size);
  assign w_beat_data = (w_rd_inwin && w_rd_bok) ? w_mem_rdata : '0;
  assign w_beat_resp = !w_rd_inwin ? DECERR : (!w_rd_bok ? SLVERR : OKAY);

  axi_s1_mem_array #(
    .WORDS (MEM_WORDS),
    .IDXW  (IDXW)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_mem_we),
    .i_widx  (word_idx(r_waddr)),
    .i_wbe   (wstrb),
    .i_wdata (wdata),
    .i_ridx  (word_idx(w_rd_addr)),
    .o_rdata (w_mem_rdata)
  );

  // Write FSM: accept address, consume beats until wlast, then report one response.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_wstate  <= W_IDLE;
      r_awid    <= '0;
      r_waddr   <= '0;
      r_wburst  <= '0;
      r_wsize   <= '0;
      r_slverr  <= 1'b0;
      r_decerr  <= 1'b0;
      r_awready <= 1'b1;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
      r_bresp   <= '0;
`ifdef AXI_S1_WAIT_STATE_EN
      r_wcnt    <= '0;
`endif
    end else begin
      case (r_wstate)
        W_IDLE: if (awvalid) begin
          r_awid    <= awid;
          r_waddr   <= awaddr;
          r_wburst  <= awburst;
          r_wsize   <= awsize;
          r_slverr  <= 1'b0;
          r_decerr  <= 1'b0;
          r_awready <= 1'b0;
          r_wready  <= 1'b1;
          r_wstate  <= W_DATA;
        end
        W_DATA: if (wvalid) begin
          if (!w_wr_bok)   r_slverr <= 1'b1;
          if (!w_wr_inwin) r_decerr <= 1'b1;
          r_waddr <= next_addr(r_waddr, r_wburst);
          if (wlast) begin
            r_wready <= 1'b0;
            r_wstate <= W_WAIT;
`ifdef AXI_S1_WAIT_STATE_EN
            r_wcnt   <= 8'(RESP_DELAY);
`endif
          end
        end
        W_WAIT: begin
`ifdef AXI_S1_WAIT_STATE_EN
          if (r_wcnt > 8'd1) begin
            r_wcnt <= r_wcnt - 8'd1;
          end else begin
`else
          begin
`endif
            r_bvalid <= 1'b1;
            r_bid    <= r_awid;
            r_bresp  <= r_decerr ? DECERR : (r_slverr ? SLVERR : OKAY);
            r_wstate <= W_RESP;
          end
        end
        W_RESP: if (bready) begin
          r_bvalid  <= 1'b0;
          r_awready <= 1'b1;
          r_wstate  <= W_IDLE;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read FSM: each beat is registered into the R outputs and held until rready.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r_rstate  <= R_IDLE;
      r_raddr   <= '0;
      r_rburst  <= '0;
      r_rsize   <= '0;
      r_rlen    <= '0;
      r_rbeat   <= '0;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_rresp   <= '0;
`ifdef AXI_S1_WAIT_STATE_EN
      r_rcnt    <= '0;
`endif
    end else begin
      case (r_rstate)
        R_IDLE: if (arvalid) begin
          r_rid     <= arid;
          r_rburst  <= arburst;
          r_rsize   <= arsize;
          r_rlen    <= arlen;
          r_arready <= 1'b0;
`ifdef AXI_S1_WAIT_STATE_EN
          r_raddr   <= araddr;
          r_rbeat   <= '0;
          r_rcnt    <= 8'(RESP_DELAY);
          r_rstate  <= R_WAIT;
`else
          r_rdata   <= w_beat_data;
          r_rresp   <= w_beat_resp;
          r_rlast   <= (arlen == 8'd0);
          r_rvalid  <= 1'b1;
          r_rbeat   <= 8'd1;
          r_raddr   <= next_addr(araddr, arburst);
          r_rstate  <= R_DATA;
`endif
        end
        R_WAIT: begin
`ifdef AXI_S1_WAIT_STATE_EN
          if (r_rcnt > 8'd1) begin
            r_rcnt <= r_rcnt - 8'd1;
          end else begin
            r_rdata  <= w_beat_data;
            r_rresp  <= w_beat_resp;
            r_rlast  <= (r_rbeat == r_rlen);
            r_rvalid <= 1'b1;
            r_rbeat  <= r_rbeat + 8'd1;
            r_raddr  <= next_addr(r_raddr, r_rburst);
            r_rstate <= R_DATA;
          end
`else
          r_rstate <= R_DATA;
`endif
        end
        R_DATA: if (rready) begin
          if (r_rlast) begin
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end else begin
`ifdef AXI_S1_WAIT_STATE_EN
            r_rvalid <= 1'b0;
            r_rcnt   <= 8'(RESP_DELAY);
            r_rstate <= R_WAIT;
`else
            r_rdata  <= w_beat_data;
            r_rresp  <= w_beat_resp;
            r_rlast  <= (r_rbeat == r_rlen);
            r_rbeat  <= r_rbeat + 8'd1;
            r_raddr  <= next_addr(r_raddr, r_rburst);
`endif
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign awready = r_awready;
  assign wready  = r_wready;
  assign bvalid  = r_bvalid;
  assign bid     = r_bid;
  assign bresp   = r_bresp;
  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rlast   = r_rlast;
  assign rid     = r_rid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;

endmodule

// File: doc/axi_slave1_mem.md
AXI_SLAVE1_MEM -- requirements
Module: axi_slave1_mem

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_2000, slave 1 window base.
REQ-002 SHALL have parameter MEM_WORDS, default 1024, number of 32-bit storage words; window = BASE_ADDR .. BASE_ADDR+4*MEM_WORDS-1.
REQ-003 SHALL have parameter RESP_DELAY, default 2, wait-state cycles; used only under AXI_S1_WAIT_STATE_EN.
REQ-004 SHALL have one clock and asynchronous active-high reset: clk  input  1  rising-edge clock; rstn  input  1  async reset, asserted when 1.
REQ-005 SHALL have AW ports: awid in 6, awaddr in 32, awlen in 8, awsize in 3, awburst in 2, awvalid in 1, awready out 1.
REQ-006 SHALL have W ports: wdata in 32, wstrb in 4, wlast in 1, wvalid in 1, wready out 1.
REQ-007 SHALL have B ports: bid out 6, bresp out 2, bvalid out 1, bready in 1.
REQ-008 SHALL have AR ports: arid in 6, araddr in 32, arlen in 8, arsize in 3, arburst in 2, arvalid in 1, arready out 1.
REQ-009 SHALL have R ports: rid out 6, rdata out 32, rresp out 2, rlast out 1, rvalid out 1, rready in 1.

Function
REQ-010 Write FSM SHALL use states W_IDLE, W_DATA, W_WAIT, W_RESP; awready=1 only in W_IDLE.
REQ-011 AW handshake SHALL latch id/addr/len/size/burst and move W_IDLE->W_DATA next cycle.
REQ-012 wready SHALL be 1 only in W_DATA; each W handshake SHALL write bytes enabled by wstrb to word addr[11:2]-relative index, then advance address per burst type.
REQ-013 INCR SHALL add 4 per beat; FIXED SHALL hold address; WRAP or size!=2 SHALL suppress all writes and give SLVERR (2'b10), beats still consumed.
REQ-014 Beat whose address lies outside window SHALL be suppressed; burst response SHALL be DECERR (2'b11) if any beat was outside, DECERR taking priority over SLVERR.
REQ-015 W handshake with wlast=1 SHALL move to W_WAIT; wlast mismatch with awlen count SHALL be ignored, burst ending on wlast.
REQ-016 BVALID SHALL assert in W_RESP with latched bid and accumulated bresp (OKAY 2'b00 otherwise), hold stable until bready, then return to W_IDLE.
REQ-017 Read FSM SHALL use states R_IDLE, R_WAIT, R_DATA; arready=1 only in R_IDLE.
REQ-018 Without wait states, first RVALID SHALL assert the cycle after AR handshake; subsequent beats back-to-back while rready=1.
REQ-019 rdata/rresp/rlast/rid SHALL stay stable while rvalid=1 and rready=0; rlast=1 exactly on beat arlen+1.
REQ-020 Out-of-window read beat SHALL return rdata=0, rresp DECERR; WRAP or size!=2 SHALL return rdata=0, SLVERR on all beats.
REQ-021 Read and write FSMs SHALL be independent; simultaneous write and read of same word in one cycle SHALL return old data.
REQ-022 Storage SHALL be synchronous-write, not reset; unwritten reads return X in simulation.

Reset
REQ-023 rstn=1 SHALL immediately force W_IDLE, R_IDLE, awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bid=0, rid=0, bresp=0, rresp=0, rdata=0.
REQ-024 Reset mid-burst SHALL abandon the burst without response; words already written SHALL keep contents.

Configuration
REQ-025 With AXI_S1_WAIT_STATE_EN defined, W_WAIT SHALL last RESP_DELAY cycles before W_RESP, and R_WAIT SHALL insert RESP_DELAY cycles before every R beat.
REQ-026 Without AXI_S1_WAIT_STATE_EN, W_WAIT and R_WAIT SHALL be zero-length (pass through in one cycle), RESP_DELAY unused.

Structure
REQ-027 Package axi_noc_pkg SHALL hold resp constants (OKAY, EXOKAY, SLVERR, DECERR), burst constants (FIXED, INCR, WRAP), S1_BASE_ADDR/S1_END_ADDR and FSM state enums.
REQ-028 Storage SHALL be sub-module axi_s1_mem_array (byte-enabled 32-bit single-write, single-read RAM).

Verification
REQ-029 Single write 0x2004 data 0xDEAD_BEEF strb 4'hF, then read 0x2004 -> BRESP 00, RDATA 0xDEAD_BEEF, RLAST 1.
REQ-030 INCR write awlen=3 at 0x2FF8 -> beats 0x2FF8/0x2FFC written, beats 2-3 suppressed, BRESP 11.
REQ-031 Read awlen=7 INCR at 0x2100 with rready toggling 1/0 -> 8 beats in order, data stable during stalls, rlast on 8th.
REQ-032 Write 0x2010 strb 4'b0011 data 0x1234_5678 over prior 0xFFFF_FFFF -> read 0xFFFF_5678.
REQ-033 Assert rstn during beat 2 of 4-beat write -> bvalid never asserts, awready=1 after reset, beat 1 data retained.
REQ-034 With AXI_S1_WAIT_STATE_EN, RESP_DELAY=2: single read -> RVALID 3 cycles after AR handshake; single write -> BVALID 3 cycles after wlast handshake.
